// File: rtl/fw_pkt_nibble_tx.sv
// fw_pkt_nibble_tx: serialises an Ethernet / optional 802.1Q / IPv4 / L4 header
// as a 4-bit nibble stream (MS nibble of each field first) with a first-nibble
// strobe, in the format the firewall header parser consumes.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 send one header (sampled only while idle)
//   Dstmac .. icmp_type_code  header fields, latched on an accepted start
//   d                     nibble stream (0 while valid is low)
//   strobe                high on the first nibble of a header
//   valid                 high while d carries a header nibble
//   busy                  high from accepted start until done
//   done                  one-cycle pulse after the last nibble
module fw_pkt_nibble_tx #(
    parameter logic [7:0]  TTL   = 8'h40,
    parameter logic [15:0] IP_ID = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [47:0] Dstmac,
    input  logic [47:0] Srcmac,
    input  logic        vlan,
    input  logic [15:0] vlan_tci,
    input  logic [15:0] Ethproto,
    input  logic [15:0] Iplen,
    input  logic [1:0]  fragment_flag,
    input  logic [12:0] fragment_shift,
    input  logic [7:0]  Ipproto,
    input  logic [31:0] srcip4,
    input  logic [31:0] dstip4,
    input  logic [15:0] Srcport,
    input  logic [15:0] Dstport,
    input  logic [15:0] icmp_type_code,
    output logic [3:0]  d,
    output logic        strobe,
    output logic        valid,
    output logic        busy,
    output logic        done
);

    localparam int unsigned VEC_W = 160;
    localparam int unsigned CNT_W = 7;

    typedef enum logic [3:0] {
        IDLE, PREP, DMAC, SMAC, VTPID, VTCI, ETYPE, IPHDR, L4, DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    // Field registers captured on an accepted start
    logic [47:0] dmac_q, smac_q;
    logic        vlan_q;
    logic [15:0] tci_q, etype_q, iplen_q, sport_q, dport_q, icmp_q, csum_q;
    logic [1:0]  fflag_q;
    logic [12:0] fshift_q;
    logic [7:0]  proto_q;
    logic [31:0] srcip_q, dstip_q;

    logic is_ipv4_c, is_tcpudp_c, is_icmp_c;
    assign is_ipv4_c   = (etype_q == 16'h0800);
    assign is_tcpudp_c = (proto_q == 8'h06) || (proto_q == 8'h11);
    assign is_icmp_c   = (proto_q == 8'h01);

    // IPv4 header checksum: ones-complement sum, two carry folds, invert
    logic [19:0] sum_c;
    logic [16:0] fold1_c;
    logic [15:0] fold2_c, csum_c;
    always_comb begin
        sum_c   = 20'(16'h4500) + 20'(iplen_q) + 20'(IP_ID)
                + 20'({1'b0, fflag_q, fshift_q}) + 20'({TTL, proto_q})
                + 20'(srcip_q[31:16]) + 20'(srcip_q[15:0])
                + 20'(dstip_q[31:16]) + 20'(dstip_q[15:0]);
        fold1_c = 17'(sum_c[15:0]) + 17'(sum_c[19:16]);
        fold2_c = fold1_c[15:0] + 16'(fold1_c[16]);
        csum_c  = ~fold2_c;
    end

    logic [VEC_W-1:0] ip_hdr_c;
    assign ip_hdr_c = {16'h4500, iplen_q, IP_ID, 1'b0, fflag_q, fshift_q,
                       TTL, proto_q, csum_q, srcip_q, dstip_q};

    // Next state / nibble index, and the nibble to present in that slot
    state_t           nxt_state;
    logic [CNT_W-1:0] nxt_cnt;
    logic [VEC_W-1:0] vec_c, shifted_c;
    logic [3:0]       nib_c;
    logic             emit_c;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 7'd1;
        case (state)
            IDLE: begin
                nxt_cnt = '0;
                if (start) nxt_state = PREP;
            end
            PREP: begin
                nxt_state = DMAC;
                nxt_cnt   = '0;
            end
            DMAC: if (cnt == 7'd11) begin
                nxt_state = SMAC;
                nxt_cnt   = '0;
            end
            SMAC: if (cnt == 7'd11) begin
                nxt_state = vlan_q ? VTPID : ETYPE;
                nxt_cnt   = '0;
            end
            VTPID: if (cnt == 7'd3) begin
                nxt_state = VTCI;
                nxt_cnt   = '0;
            end
            VTCI: if (cnt == 7'd3) begin
                nxt_state = ETYPE;
                nxt_cnt   = '0;
            end
            ETYPE: if (cnt == 7'd3) begin
                nxt_state = is_ipv4_c ? IPHDR : DONE;
                nxt_cnt   = '0;
            end
            IPHDR: if (cnt == 7'd39) begin
                nxt_state = (is_tcpudp_c || is_icmp_c) ? L4 : DONE;
                nxt_cnt   = '0;
            end
            L4: if (cnt == (is_tcpudp_c ? 7'd7 : 7'd3)) begin
                nxt_state = DONE;
                nxt_cnt   = '0;
            end
            DONE: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
        endcase

        // Each field is left-aligned so nibble n sits at the top after a 4n shift
        vec_c = '0;
        case (nxt_state)
            DMAC:    vec_c = {dmac_q, 112'd0};
            SMAC:    vec_c = {smac_q, 112'd0};
            VTPID:   vec_c = {16'h8100, 144'd0};
            VTCI:    vec_c = {tci_q, 144'd0};
            ETYPE:   vec_c = {etype_q, 144'd0};
            IPHDR:   vec_c = ip_hdr_c;
            L4:      vec_c = is_tcpudp_c ? {sport_q, dport_q, 128'd0}
                                         : {icmp_q, 144'd0};
            default: vec_c = '0;
        endcase
        shifted_c = vec_c << {nxt_cnt, 2'b00};
        nib_c     = shifted_c[VEC_W-1 -: 4];
        emit_c    = (nxt_state != IDLE) && (nxt_state != PREP) && (nxt_state != DONE);
    end

    // State, field capture, checksum and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            dmac_q   <= '0;
            smac_q   <= '0;
            vlan_q   <= 1'b0;
            tci_q    <= '0;
            etype_q  <= '0;
            iplen_q  <= '0;
            fflag_q  <= '0;
            fshift_q <= '0;
            proto_q  <= '0;
            srcip_q  <= '0;
            dstip_q  <= '0;
            sport_q  <= '0;
            dport_q  <= '0;
            icmp_q   <= '0;
            csum_q   <= '0;
            d        <= '0;
            strobe   <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            if (state == IDLE && start) begin
                dmac_q   <= Dstmac;
                smac_q   <= Srcmac;
                vlan_q   <= vlan;
                tci_q    <= vlan_tci;
                etype_q  <= Ethproto;
                iplen_q  <= Iplen;
                fflag_q  <= fragment_flag;
                fshift_q <= fragment_shift;
                proto_q  <= Ipproto;
                srcip_q  <= srcip4;
                dstip_q  <= dstip4;
                sport_q  <= Srcport;
                dport_q  <= Dstport;
                icmp_q   <= icmp_type_code;
            end
            if (state == PREP) csum_q <= csum_c;
            d      <= emit_c ? nib_c : 4'd0;
            valid  <= emit_c;
            strobe <= (nxt_state == DMAC) && (nxt_cnt == '0);
            busy   <= (nxt_state != IDLE) && (nxt_state != DONE);
            done   <= (nxt_state == DONE);
        end
    end

endmodule

// File: tb/tb_fw_pkt_nibble_tx.sv
// Self-checking bench for fw_pkt_nibble_tx: directed and random headers are
// compared nibble-by-nibble against a field-level reference model.
module tb_fw_pkt_nibble_tx;

    localparam logic [7:0]  TTL_V   = 8'h40;
    localparam logic [15:0] IP_ID_V = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [47:0] Dstmac, Srcmac;
    logic        vlan;
    logic [15:0] vlan_tci, Ethproto, Iplen, Srcport, Dstport, icmp_type_code;
    logic [1:0]  fragment_flag;
    logic [12:0] fragment_shift;
    logic [7:0]  Ipproto;
    logic [31:0] srcip4, dstip4;
    logic [3:0]  d;
    logic        strobe, valid, busy, done;

    int errors = 0;
    int checks = 0;
    string cur_name;

    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];

    fw_pkt_nibble_tx dut (
        .clk(clk), .reset(reset), .start(start),
        .Dstmac(Dstmac), .Srcmac(Srcmac), .vlan(vlan), .vlan_tci(vlan_tci),
        .Ethproto(Ethproto), .Iplen(Iplen), .fragment_flag(fragment_flag),
        .fragment_shift(fragment_shift), .Ipproto(Ipproto),
        .srcip4(srcip4), .dstip4(dstip4), .Srcport(Srcport), .Dstport(Dstport),
        .icmp_type_code(icmp_type_code),
        .d(d), .strobe(strobe), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", cur_name, tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] gn(input int i);
        if (i >= 0 && i < got_q.size()) return got_q[i];
        return 4'hx;
    endfunction

    function automatic void push_f(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[4*i +: 4]);
    endfunction

    // Reference: header as a sequence of fields, checksum by repeated folding
    function automatic void build_model();
        int unsigned s;
        logic [15:0] ck;
        exp_q.delete();
        push_f(64'(Dstmac), 12);
        push_f(64'(Srcmac), 12);
        if (vlan) begin
            push_f(64'h8100, 4);
            push_f(64'(vlan_tci), 4);
        end
        push_f(64'(Ethproto), 4);
        if (Ethproto == 16'h0800) begin
            s = 32'h4500 + 32'(Iplen) + 32'(IP_ID_V)
              + 32'({1'b0, fragment_flag, fragment_shift}) + 32'({TTL_V, Ipproto})
              + 32'(srcip4 >> 16) + 32'(srcip4 & 32'hFFFF)
              + 32'(dstip4 >> 16) + 32'(dstip4 & 32'hFFFF);
            while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
            ck = ~16'(s);
            push_f(64'h4500, 4);
            push_f(64'(Iplen), 4);
            push_f(64'(IP_ID_V), 4);
            push_f(64'({1'b0, fragment_flag, fragment_shift}), 4);
            push_f(64'(TTL_V), 2);
            push_f(64'(Ipproto), 2);
            push_f(64'(ck), 4);
            push_f(64'(srcip4), 8);
            push_f(64'(dstip4), 8);
            if (Ipproto == 8'h06 || Ipproto == 8'h11) begin
                push_f(64'(Srcport), 4);
                push_f(64'(Dstport), 4);
            end else if (Ipproto == 8'h01) begin
                push_f(64'(icmp_type_code), 4);
            end
        end
    endfunction

    task automatic set_udp();
        Dstmac = 48'h0011_2233_4455; Srcmac = 48'h6677_8899_AABB;
        vlan = 1'b0; vlan_tci = 16'h0000; Ethproto = 16'h0800; Iplen = 16'h001C;
        fragment_flag = 2'b00; fragment_shift = 13'h0000; Ipproto = 8'h11;
        srcip4 = 32'hC0A8_0001; dstip4 = 32'hC0A8_00C7;
        Srcport = 16'h1234; Dstport = 16'h0035; icmp_type_code = 16'h0000;
    endtask

    task automatic scramble_inputs();
        Dstmac = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        Srcmac = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        vlan = 1'($urandom); vlan_tci = 16'($urandom); Iplen = 16'($urandom);
        fragment_flag = 2'($urandom); fragment_shift = 13'($urandom);
        srcip4 = $urandom; dstip4 = $urandom; Srcport = 16'($urandom);
        Dstport = 16'($urandom); icmp_type_code = 16'($urandom);
        case ($urandom_range(0, 3))
            0, 1:    Ethproto = 16'h0800;
            2:       Ethproto = 16'h0806;
            default: Ethproto = 16'($urandom);
        endcase
        case ($urandom_range(0, 4))
            0:       Ipproto = 8'h06;
            1:       Ipproto = 8'h11;
            2:       Ipproto = 8'h01;
            3:       Ipproto = 8'h2F;
            default: Ipproto = 8'($urandom);
        endcase
    endtask

    // Send one header and check framing and every nibble against the model;
    // optionally pulse start mid-frame and change inputs after latching.
    task automatic run_frame(input int mid_start, input bit scramble);
        int first_v, last_v, done_c, strobe_c, strobes, extra;
        build_model();
        got_q.delete();
        first_v = -1; last_v = -1; done_c = -1; strobe_c = -1; strobes = 0; extra = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (scramble) scramble_inputs();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start = (c == mid_start);
            if (c == 0) chk("busy_after_start", 32'(busy), 1);
            if (valid) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                got_q.push_back(d);
            end
            if (strobe) begin
                strobes++;
                strobe_c = c;
            end
            if (done) begin
                done_c = c;
                chk("busy_at_done", 32'(busy), 0);
                break;
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(done_c >= 0), 1);
        chk("length", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("nib%0d", i), 32'(gn(i)), 32'(exp_q[i]));
        chk("strobe_count", 32'(strobes), 1);
        chk("strobe_on_first", 32'(strobe_c), 32'(first_v));
        chk("first_nibble_latency", 32'(first_v), 1);
        chk("done_after_last", 32'(done_c - last_v), 1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (valid || busy || strobe) extra++;
        end
        chk("quiet_after_done", 32'(extra), 0);
    endtask

    initial begin
        logic [3:0] d_before;
        int seen;
        reset = 1'b1; start = 1'b0;
        set_udp();
        repeat (2) @(posedge clk);
        @(negedge clk);
        cur_name = "reset";
        chk("d", 32'(d), 0);
        chk("strobe", 32'(strobe), 0);
        chk("valid", 32'(valid), 0);
        chk("busy", 32'(busy), 0);
        chk("done", 32'(done), 0);
        reset = 1'b0;

        cur_name = "udp";
        set_udp();
        run_frame(-1, 1'b0);
        chk("len76", 32'(got_q.size()), 76);
        chk("first4", {16'h0, gn(0), gn(1), gn(2), gn(3)}, 32'h0011);
        chk("csum", {16'h0, gn(48), gn(49), gn(50), gn(51)}, 32'hF8B8);

        cur_name = "vlan";
        set_udp(); vlan = 1'b1; vlan_tci = 16'h0064;
        run_frame(-1, 1'b0);
        chk("len84", 32'(got_q.size()), 84);
        chk("tag", {gn(24), gn(25), gn(26), gn(27), gn(28), gn(29), gn(30), gn(31)}, 32'h8100_0064);
        chk("csum_shift", {16'h0, gn(56), gn(57), gn(58), gn(59)}, 32'hF8B8);

        cur_name = "arp";
        set_udp(); Ethproto = 16'h0806;
        run_frame(-1, 1'b0);
        chk("len28", 32'(got_q.size()), 28);
        chk("etype", {16'h0, gn(24), gn(25), gn(26), gn(27)}, 32'h0806);

        cur_name = "icmp";
        set_udp(); Ipproto = 8'h01; icmp_type_code = 16'h0800;
        run_frame(-1, 1'b0);
        chk("len72", 32'(got_q.size()), 72);
        chk("tail", {16'h0, gn(68), gn(69), gn(70), gn(71)}, 32'h0800);

        cur_name = "gre";
        set_udp(); Ipproto = 8'h2F;
        run_frame(-1, 1'b0);
        chk("len68", 32'(got_q.size()), 68);

        cur_name = "frag_scramble";
        set_udp(); fragment_flag = 2'b10; fragment_shift = 13'h0123; Ipproto = 8'h06;
        run_frame(-1, 1'b1);

        cur_name = "start_while_busy";
        set_udp();
        run_frame(20, 1'b0);

        // Asynchronous reset in the middle of a header
        cur_name = "mid_reset";
        set_udp(); vlan = 1'b1; vlan_tci = 16'h0064;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && seen < 31; c++) begin
            @(negedge clk);
            if (valid) seen++;
        end
        chk("reached_nib30", 32'(seen), 31);
        d_before = d;
        chk("d_before_reset", 32'(d_before), 6);
        #1 reset = 1'b1;
        #1;
        chk("d_async", 32'(d), 0);
        chk("valid_async", 32'(valid), 0);
        chk("busy_async", 32'(busy), 0);
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        cur_name = "after_reset";
        run_frame(-1, 1'b0);

        for (int k = 0; k < 20; k++) begin
            cur_name = $sformatf("rand%0d", k);
            scramble_inputs();
            run_frame((k % 4 == 0) ? 10 : -1, 1'(k % 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
